// File: rtl/mult_pkg.sv
// Shared constants and Booth digit encoding for the 16x16 multiplier datapath.
package mult_pkg;

    localparam int MULT_W   = 16;
    localparam int MULT_PPW = MULT_W + 2;
    localparam int MULT_NPP = MULT_W / 2 + 1;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_dig_t;

    localparam booth_dig_t BOOTH_ZERO = '{neg: 1'b0, one: 1'b0, two: 1'b0};
    localparam booth_dig_t BOOTH_P1   = '{neg: 1'b0, one: 1'b1, two: 1'b0};
    localparam booth_dig_t BOOTH_P2   = '{neg: 1'b0, one: 1'b0, two: 1'b1};
    localparam booth_dig_t BOOTH_M1   = '{neg: 1'b1, one: 1'b1, two: 1'b0};
    localparam booth_dig_t BOOTH_M2   = '{neg: 1'b1, one: 1'b0, two: 1'b1};

    // A digit only contributes when it selects a non-zero magnitude.
    function automatic logic booth_is_active(input booth_dig_t dig);
        return dig.one | dig.two;
    endfunction

endpackage

// File: rtl/booth_enc_r4.sv
// Radix-4 Booth encoder: one overlapping multiplier triplet -> {neg, one, two}.
module booth_enc_r4
    import mult_pkg::*;
(
    input  logic [2:0]  bits_i,
    output booth_dig_t  dig_o
);

    // Triplet decode; 111 deliberately maps to a plain zero (no negate).
    always_comb begin
        dig_o = BOOTH_ZERO;
        case (bits_i)
            3'b000:  dig_o = BOOTH_ZERO;
            3'b001:  dig_o = BOOTH_P1;
            3'b010:  dig_o = BOOTH_P1;
            3'b011:  dig_o = BOOTH_P2;
            3'b100:  dig_o = BOOTH_M2;
            3'b101:  dig_o = BOOTH_M1;
            3'b110:  dig_o = BOOTH_M1;
            3'b111:  dig_o = BOOTH_ZERO;
            default: dig_o = BOOTH_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_pp_gen.sv
// Radix-4 Booth partial-product generator: operand/digit stage, then row-select
// stage, with a stallable valid/ready handshake toward the compressor tree.
module booth_pp_gen
    import mult_pkg::*;
#(
    parameter int W   = MULT_W,
    parameter int PPW = W + 2
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [W-1:0]               a_i,
    input  logic [W-1:0]               b_i,
    input  logic                       signed_i,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [(W/2+1)*PPW-1:0]     pp_o,
    output logic [W/2:0]               neg_o
);

    localparam int NPP = W / 2 + 1;
    localparam int BW  = W + 3;

    logic                   adv_s;
    logic                   accept_s;
    logic                   ext_s;
    logic [PPW-1:0]         a_ext_s;
    logic [BW-1:0]          b_ext_s;
    booth_dig_t [NPP-1:0]   dig_s;

    logic                   s1_valid_q, s1_valid_d;
    logic [PPW-1:0]         a_ext_q, a_ext_d;
    booth_dig_t [NPP-1:0]   dig_q, dig_d;

    logic                   s2_valid_q, s2_valid_d;
    logic [NPP*PPW-1:0]     pp_q, pp_d;
    logic [NPP-1:0]         neg_q, neg_d;

    logic [NPP*PPW-1:0]     row_s;
    logic [NPP-1:0]         rneg_s;
    logic [PPW-1:0]         mag_s;

    assign adv_s    = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || adv_s;
    assign accept_s = in_valid && in_ready;

    // Operand extension; unsigned operands simply see zero in the extension bits.
    assign ext_s   = signed_i & b_i[W-1];
    assign a_ext_s = {{(PPW-W){signed_i & a_i[W-1]}}, a_i};
    assign b_ext_s = {ext_s, ext_s, b_i, 1'b0};

    for (genvar k = 0; k < NPP; k++) begin : g_enc
        booth_enc_r4 u_enc (
            .bits_i (b_ext_s[2*k +: 3]),
            .dig_o  (dig_s[k])
        );
    end

    // Stage 1 next state: capture on accept, drain into stage 2 when it advances.
    always_comb begin
        s1_valid_d = s1_valid_q;
        a_ext_d    = a_ext_q;
        dig_d      = dig_q;
        if (in_ready) begin
            s1_valid_d = in_valid;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (accept_s) begin
            a_ext_d = a_ext_s;
            dig_d   = dig_s;
        end else begin
            a_ext_d = a_ext_q;
            dig_d   = dig_q;
        end
    end

    // Row select: magnitude 0/A/2A, one's complemented for negative digits.
    always_comb begin
        row_s  = {(NPP*PPW){1'b0}};
        rneg_s = {NPP{1'b0}};
        mag_s  = {PPW{1'b0}};
        for (int k = 0; k < NPP; k++) begin
            if (dig_q[k].two) begin
                mag_s = a_ext_q << 1;
            end else if (dig_q[k].one) begin
                mag_s = a_ext_q;
            end else begin
                mag_s = {PPW{1'b0}};
            end
            if (!booth_is_active(dig_q[k])) begin
                row_s[k*PPW +: PPW] = {PPW{1'b0}};
                rneg_s[k]           = 1'b0;
            end else if (dig_q[k].neg) begin
                row_s[k*PPW +: PPW] = ~mag_s;
                rneg_s[k]           = 1'b1;
            end else begin
                row_s[k*PPW +: PPW] = mag_s;
                rneg_s[k]           = 1'b0;
            end
        end
    end

    // Stage 2 next state: payload only changes when the tree can take it.
    always_comb begin
        s2_valid_d = s2_valid_q;
        pp_d       = pp_q;
        neg_d      = neg_q;
        if (adv_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                pp_d  = row_s;
                neg_d = rneg_s;
            end else begin
                pp_d  = pp_q;
                neg_d = neg_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            a_ext_q    <= {PPW{1'b0}};
            dig_q      <= {NPP{BOOTH_ZERO}};
            s2_valid_q <= 1'b0;
            pp_q       <= {(NPP*PPW){1'b0}};
            neg_q      <= {NPP{1'b0}};
        end else begin
            s1_valid_q <= s1_valid_d;
            a_ext_q    <= a_ext_d;
            dig_q      <= dig_d;
            s2_valid_q <= s2_valid_d;
            pp_q       <= pp_d;
            neg_q      <= neg_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign pp_o      = pp_q;
    assign neg_o     = neg_q;

endmodule

// File: tb/tb_booth_pp_gen.sv
// Self-checking bench for booth_pp_gen: arithmetic Booth model + scoreboard + directed literals.
module tb_booth_pp_gen;

    localparam int W   = 16;
    localparam int PPW = 18;
    localparam int NPP = 9;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [W-1:0]         a_i = 16'h0000;
    logic [W-1:0]         b_i = 16'h0000;
    logic                 signed_i = 1'b0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [NPP*PPW-1:0]   pp_o;
    logic [NPP-1:0]       neg_o;

    booth_pp_gen #(.W(W), .PPW(PPW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_i(a_i), .b_i(b_i), .signed_i(signed_i), .out_valid(out_valid),
        .out_ready(out_ready), .pp_o(pp_o), .neg_o(neg_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
    } item_t;

    item_t exp_q[$];
    int checks = 0;
    int failures = 0;
    int out_cnt = 0;
    logic held_v = 1'b0;
    logic [NPP*PPW+NPP-1:0] held;

    task automatic chk(input logic ok, input string name, input logic [199:0] act, input logic [199:0] req);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Rows from digit value d: d*A when positive, d*A-1 (i.e. ~|d*A|) plus neg when negative.
    function automatic logic [NPP*PPW+NPP-1:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
        logic [NPP*PPW-1:0] pp;
        logic [NPP-1:0]     ng;
        logic [18:0]        bext;
        logic               e;
        int                 av, d, p;
        pp = '0;
        ng = '0;
        av = s ? int'($signed(a)) : int'(a);
        e  = s & b[15];
        bext = {e, e, b, 1'b0};
        for (int k = 0; k < NPP; k++) begin
            d = (bext[2*k] ? 1 : 0) + (bext[2*k+1] ? 1 : 0) - (bext[2*k+2] ? 2 : 0);
            p = d * av;
            if (d > 0) begin
                pp[k*PPW +: PPW] = p[17:0];
            end else if (d < 0) begin
                p = p - 1;
                pp[k*PPW +: PPW] = p[17:0];
                ng[k] = 1'b1;
            end
        end
        return {pp, ng};
    endfunction

    function automatic logic [31:0] reduce(input logic [NPP*PPW-1:0] pp, input logic [NPP-1:0] ng);
        logic signed [63:0] acc;
        logic signed [17:0] r;
        acc = 64'sd0;
        for (int k = 0; k < NPP; k++) begin
            r = pp[k*PPW +: PPW];
            acc = acc + ((longint'(r) + longint'(ng[k])) <<< (2*k));
        end
        return acc[31:0];
    endfunction

    function automatic logic [31:0] product(input logic [15:0] a, input logic [15:0] b, input logic s);
        int sp;
        logic [31:0] up;
        sp = int'($signed(a)) * int'($signed(b));
        up = 32'(a) * 32'(b);
        return s ? sp : up;
    endfunction

    // Scoreboard compare: every valid output cycle against the model of the oldest accepted item.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held_v <= 1'b0;
        end else begin
            if (held_v) begin
                chk(out_valid && ({pp_o, neg_o} == held), "stall_hold", {out_valid, pp_o, neg_o}, {1'b1, held});
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "spurious_out", {pp_o, neg_o}, 200'h0);
                end else begin
                    chk({pp_o, neg_o} == model(exp_q[0].a, exp_q[0].b, exp_q[0].s), "model_rows",
                        {pp_o, neg_o}, model(exp_q[0].a, exp_q[0].b, exp_q[0].s));
                    chk(reduce(pp_o, neg_o) == product(exp_q[0].a, exp_q[0].b, exp_q[0].s), "reduction",
                        reduce(pp_o, neg_o), product(exp_q[0].a, exp_q[0].b, exp_q[0].s));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        out_cnt++;
                    end
                end
            end
            held_v <= out_valid && !out_ready;
            held   <= {pp_o, neg_o};
            if (in_valid && in_ready) exp_q.push_back('{a: a_i, b: b_i, s: signed_i});
        end
    end

    task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic s,
                           input logic [31:0] exp_red, input string name);
        @(posedge clk); #1;
        a_i = a; b_i = b; signed_i = s; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk(in_ready == 1'b1, "accept_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk(out_valid == 1'b0, "latency_c1", out_valid, 1'b0);
        @(negedge clk);
        chk(out_valid == 1'b1, "latency_c2", out_valid, 1'b1);
        chk(reduce(pp_o, neg_o) == exp_red, name, reduce(pp_o, neg_o), exp_red);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
    endtask

    logic [NPP*PPW-1:0] lit_pp;
    logic [NPP*PPW+NPP-1:0] lit_all;
    int base_cnt;
    int waited;

    initial begin
        #2;
        chk(out_valid == 1'b0 && pp_o == '0 && neg_o == '0, "reset_state", {out_valid, pp_o, neg_o}, 200'h0);
        chk(in_ready == 1'b1, "reset_in_ready", in_ready, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // Unsigned all-ones: row0 = -1 (~A), rows1-7 zero, row8 = +A.
        lit_pp = '0;
        lit_pp[0 +: PPW]     = 18'h30000;
        lit_pp[8*PPW +: PPW] = 18'h0FFFF;
        lit_all = {lit_pp, 9'h001};
        chk(model(16'hFFFF, 16'hFFFF, 1'b0) == lit_all, "model_pin_ffff", model(16'hFFFF, 16'hFFFF, 1'b0), lit_all);
        run_one(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "red_ffff_u");
        chk({pp_o, neg_o} == lit_all, "rows_ffff_u", {pp_o, neg_o}, lit_all);

        // Signed -32768^2: only row7 (-2) active, row8 from 111 is zero.
        run_one(16'h8000, 16'h8000, 1'b1, 32'h40000000, "red_8000_s");
        chk(pp_o[8*PPW +: PPW] == 18'h0 && neg_o == 9'h080, "row8_zero_s",
            {pp_o[8*PPW +: PPW], neg_o}, {18'h0, 9'h080});
        chk(pp_o[7*PPW +: PPW] == 18'h0FFFF, "row7_m2_s", pp_o[7*PPW +: PPW], 18'h0FFFF);
        run_one(16'h0003, 16'hFFFF, 1'b1, 32'hFFFFFFFD, "red_3xm1_s");
        chk(pp_o[0 +: PPW] == 18'h3FFFC && neg_o == 9'h001, "row0_m1_s", {pp_o[0 +: PPW], neg_o}, {18'h3FFFC, 9'h001});
        idle(3);

        // Back-pressure: two accepted, third blocked until release.
        out_ready = 1'b0;
        a_i = 16'h1234; b_i = 16'h00F3; signed_i = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        chk(in_ready == 1'b1, "bp_acc1", in_ready, 1'b1);
        @(posedge clk); #1;
        a_i = 16'hBEEF; b_i = 16'h8001; signed_i = 1'b1;
        @(negedge clk);
        chk(in_ready == 1'b1, "bp_acc2", in_ready, 1'b1);
        @(posedge clk); #1;
        a_i = 16'h7FFF; b_i = 16'h5555; signed_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk(in_ready == 1'b0 && out_valid == 1'b1, "bp_full", {in_ready, out_valid}, 2'b01);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk(in_ready == 1'b1, "bp_release", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        idle(4);
        chk(exp_q.size() == 0, "bp_drained", exp_q.size(), 0);

        // Streaming: back-to-back with no bubbles.
        base_cnt = out_cnt;
        for (int i = 0; i < 100; i++) begin
            a_i = 16'($urandom); b_i = 16'($urandom); signed_i = 1'($urandom_range(0, 1));
            in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            if (in_ready !== 1'b1) chk(1'b0, "stream_ready", in_ready, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        idle(4);
        chk(out_cnt - base_cnt == 100, "stream_count", out_cnt - base_cnt, 100);

        // Reset with both stages full.
        out_ready = 1'b0;
        a_i = 16'hAAAA; b_i = 16'h5555; signed_i = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        a_i = 16'h1111; b_i = 16'h2222;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk(out_valid == 1'b1 && in_ready == 1'b0, "pre_rst_full", {out_valid, in_ready}, 2'b10);
        #2 rst = 1'b1;
        #1;
        chk(out_valid == 1'b0 && pp_o == '0 && neg_o == '0, "async_rst", {out_valid, pp_o, neg_o}, 200'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        run_one(16'd5, 16'd7, 1'b0, 32'd35, "post_rst_5x7");
        idle(3);

        // Random in_valid / out_ready toggling.
        for (int i = 0; i < 400; i++) begin
            a_i = 16'($urandom); b_i = 16'($urandom); signed_i = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        chk(exp_q.size() == 0, "final_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_pp_gen.md
Name: booth_pp_gen

Overview:
- Radix-4 Booth partial-product generator for the 16x16 multiplier.
- Sits directly upstream of the 5:3 / 4:2 compressor tree.
- Registers operands, Booth-encodes the multiplier, and emits 9 partial products plus per-row negate bits.
- Two-stage valid/ready pipeline so the compressor tree can be stalled.

Parameters:
- W, 16, operand width (even; partial-product count NPP = W/2+1).
- PPW, 18, partial-product row width (W+2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands this cycle.
- a_i  in  W  multiplicand.
- b_i  in  W  multiplier.
- signed_i  in  1  1 = two's-complement operands, 0 = unsigned.
- out_valid  out  1  partial products valid.
- out_ready  in  1  compressor tree accepts this cycle.
- pp_o  out  NPP*PPW  row k at bits [k*PPW +: PPW], unshifted (tree applies weight 2^(2k)).
- neg_o  out  NPP  bit k = +1 to inject at weight 2^(2k) (completes two's complement of row k).

Behaviour:
- Reset (async, immediate): s1_valid=0, s2_valid=0, out_valid=0, pp_o=0, neg_o=0. in_ready is 1 during and after reset.
- Handshake: a transfer occurs when valid&&ready are both high on a rising edge. Payload is held stable while out_valid=1 and out_ready=0.
- Stage 1 (on in_valid&&in_ready): capture a_i, b_i, signed_i; s1_valid<=1.
- Operand extension in stage 1:
  - a_ext (PPW bits) = signed ? sign-extend(a) : zero-extend(a).
  - b_ext (W+3 bits) = {e, e, b, 0}, where e = signed ? b[W-1] : 0.
- Booth digit k (k=0..NPP-1) uses bits b_ext[2k+2 : 2k]:
  - 000, 111 -> 0
  - 001, 010 -> +1
  - 011 -> +2
  - 100 -> -2
  - 101, 110 -> -1
- Encoded digit per row: {neg, one, two}, registered with a_ext at the end of stage 1.
- Stage 2 row select:
  - M = two ? a_ext<<1 : one ? a_ext : 0.
  - pp_k = neg ? ~M : M; neg_k = neg.
  - A zero digit always gives pp_k = 0, neg_k = 0, including pattern 111.
- Latency: 2 cycles from in accept to out_valid. Throughput 1 per cycle when out_ready=1.
- Stall logic:
  - s2 loads when !s2_valid || out_ready.
  - s1 advances under the same condition.
  - in_ready = !s1_valid || (!s2_valid || out_ready). This is combinational and gives no bubble under continuous flow.
- Simultaneous accept on input and output in the same cycle: both occur; no data lost or duplicated.
- Back-pressure: with out_ready=0 and both stages full, in_ready=0. Two items are held, nothing is overwritten.
- Reset mid-operation: all in-flight items are discarded; the first post-reset item is unaffected by them.
- Width rules:
  - PPW = W+2 holds ±2A for signed and unsigned operands.
  - The sum over k of (pp_k + neg_k)·4^k, taken mod 2^(2W) and with each row sign-extended by the tree, equals a*b.
  - Sign-extension handling (row sign bit / constant-1 trick) is the tree's responsibility; this block outputs raw rows.

Decomposition:
- Shared package mult_pkg:
  - W, PPW, NPP constants.
  - Booth digit localparams (BOOTH_ZERO, BOOTH_P1, BOOTH_P2, BOOTH_M1, BOOTH_M2).
  - Encoded-digit struct {neg, one, two}.
- One natural sub-module: booth_enc_r4, a combinational 3-bit -> {neg, one, two} encoder, instantiated NPP times in stage 1.
- Row select stays inline in stage 2.

Test Plan:
- Unsigned, a=0xFFFF, b=0xFFFF, out_ready=1:
  - out_valid exactly 2 cycles after accept.
  - Digits: row0 = -1, rows1–7 = 0, row8 = +1.
  - Weighted sum = 0xFFFE0001.
- Signed, a=0x8000, b=0x8000: signed reduction yields 0x40000000; row8 = 0 (digit from 111). Also signed a=0x0003, b=0xFFFF (-1): reduction = 0xFFFFFFFD.
- Back-pressure:
  - Issue 3 operands with out_ready=0: first two accepted, then in_ready=0.
  - Release out_ready: outputs in order, unchanged while stalled, third accepted on release.
- Streaming: 100 random (a, b, signed) back-to-back with out_ready=1; one result per cycle. Golden-model reduction matches a*b for every item.
- Reset mid-flight:
  - Assert rst while both stages are valid: out_valid=0 and pp_o=0 immediately (async).
  - After deassert, a new item (a=5, b=7, unsigned) reduces to 35.
- Random out_ready toggling at 50% with random in_valid: no drop or duplication, order preserved, payload stable while stalled.
